// File: rtl/mux8way_rr.sv
// Eight-channel valid/ready round-robin merger with a registered, source-tagged output stage.
// Define MUX8WAY_FIXED_PRIORITY_EN for fixed priority (channel 0 highest) without the last-grant register.
module mux8way_rr #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           in_valid,
    input  logic [8*WIDTH-1:0]   in_data,
    output logic [7:0]           in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [2:0]           out_sel,
    input  logic                 out_ready
);

    localparam int unsigned NCH  = 8;
    localparam int unsigned SELW = 3;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
`ifndef MUX8WAY_FIXED_PRIORITY_EN
    logic [SELW-1:0]  last_q,      last_d;
`endif

    logic             load_c;
    logic             found_c;
    logic [SELW-1:0]  grant_c;
    logic [SELW-1:0]  idx_c;
    logic [WIDTH-1:0] chan_data [NCH];

    // Unpack the flat input data bus into per-channel words.
    always_comb begin
        for (int unsigned i = 0; i < NCH; i++) begin
            chan_data[i] = in_data[i*WIDTH +: WIDTH];
        end
    end

    // Grant search: first valid channel walking from the priority start point.
    always_comb begin
        load_c  = !out_valid_q || out_ready;
        found_c = 1'b0;
        grant_c = '0;
        idx_c   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
`ifdef MUX8WAY_FIXED_PRIORITY_EN
            idx_c = SELW'(k);
`else
            idx_c = SELW'(last_q + SELW'(k) + SELW'(1));
`endif
            if (!found_c && in_valid[idx_c]) begin
                found_c = 1'b1;
                grant_c = idx_c;
            end
        end
    end

    // Handshake and next-state for the output register.
    always_comb begin
        in_ready    = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
`ifndef MUX8WAY_FIXED_PRIORITY_EN
        last_d      = last_q;
`endif
        if (load_c) begin
            if (found_c) begin
                out_valid_d = 1'b1;
                out_data_d  = chan_data[grant_c];
                out_sel_d   = grant_c;
`ifndef MUX8WAY_FIXED_PRIORITY_EN
                last_d      = grant_c;
`endif
                // Reset holds the handshake off so no word is consumed during it.
                if (!reset) begin
                    in_ready[grant_c] = 1'b1;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
`ifndef MUX8WAY_FIXED_PRIORITY_EN
            last_q      <= SELW'(7);
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
`ifndef MUX8WAY_FIXED_PRIORITY_EN
            last_q      <= last_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
